// File: rtl/input_buffer_if.sv
// Request/acknowledge flit link: producer drives req/data, consumer returns ack.
interface input_buffer_if #(
    parameter int unsigned DATA_WIDTH = 18
);
    logic                  req;
    logic [DATA_WIDTH-1:0] data;
    logic                  ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/input_buffer.sv
// Per-input-port flit FIFO: accepts flits from the link, offers the head flit to the switch.
module input_buffer #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input_buffer_if.slave          in_rack_io,
    input_buffer_if.master         out_rack_io,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_c;
    logic                  pop_c;

    // Status and handshakes depend on registered state only.
    assign full             = (count_q == CNT_W'(DEPTH));
    assign empty            = (count_q == '0);
    assign occupancy        = count_q;
    assign in_rack_io.ack   = !full;
    assign out_rack_io.req  = !empty;
    assign out_rack_io.data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_c   = in_rack_io.req && !full && !rst;
        pop_c    = out_rack_io.ack && !empty && !rst;

        if (push_c) begin
            mem_d[wr_ptr_q] = in_rack_io.data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are never exposed while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: queue reference model, per-cycle compare, directed and random traffic.
module tb_input_buffer;
    localparam int unsigned DW    = 18;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          in_req  = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ack = 1'b0;
    logic [2:0]    occupancy;
    logic          full;
    logic          empty;

    input_buffer_if #(.DATA_WIDTH(DW)) in_if ();
    input_buffer_if #(.DATA_WIDTH(DW)) out_if ();

    assign in_if.req   = in_req;
    assign in_if.data  = in_data;
    assign out_if.ack  = out_ack;

    input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_rack_io  (in_if.slave),
        .out_rack_io (out_if.master),
        .occupancy   (occupancy),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] dut_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated from the values seen at each edge.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        do_push = in_req && (model_q.size() < DEPTH);
        do_pop  = out_ack && (model_q.size() > 0);
        if (rst) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
    end

    // Compare every cycle away from the active edge; also log flits the switch takes.
    always @(negedge clk) begin
        if (check_en) begin
            check("out_req",   32'(out_if.req),  32'(model_q.size() > 0));
            check("out_data",  32'(out_if.data), (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
            check("in_ack",    32'(in_if.ack),   32'(model_q.size() < DEPTH));
            check("occupancy", 32'(occupancy),   32'(model_q.size()));
            check("full",      32'(full),        32'(model_q.size() == DEPTH));
            check("empty",     32'(empty),       32'(model_q.size() == 0));
            if (out_if.req && out_ack && !rst) dut_log.push_back(out_if.data);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] exp [$]);
        check({name, "_len"}, 32'(dut_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            check(name, 32'(dut_log[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [DW-1:0] exp [$];

        // Reset, then idle
        step();
        check_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ack",   32'(in_if.ack), 32'd1);
        check("rst_req",   32'(out_if.req), 32'd0);
        check("rst_data",  32'(out_if.data), 32'd0);
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        out_ack = 1'b1;
        repeat (3) step();
        check("idle_occ", 32'(occupancy), 32'd0);
        out_ack = 1'b0;

        // Single flit, held while ack is low
        in_req = 1'b1; in_data = 18'h2ABCD;
        step();
        in_req = 1'b0;
        check("single_req",  32'(out_if.req), 32'd1);
        check("single_data", 32'(out_if.data), 32'h2ABCD);
        check("single_occ",  32'(occupancy), 32'd1);
        repeat (2) step();
        check("single_hold", 32'(out_if.data), 32'h2ABCD);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("single_empty", 32'(empty), 32'd1);

        // Fill, hold off a fifth flit, pop while full with req high
        dut_log.delete();
        for (int i = 1; i <= 4; i++) begin
            in_req = 1'b1; in_data = DW'(i);
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_ack",  32'(in_if.ack), 32'd0);
        in_data = DW'(5);
        repeat (2) step();
        check("holdoff_occ", 32'(occupancy), 32'd4);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("fullpop_occ", 32'(occupancy), 32'd3);
        check("fullpop_ack", 32'(in_if.ack), 32'd1);
        step();
        in_req = 1'b0;
        check("refill_occ", 32'(occupancy), 32'd4);
        out_ack = 1'b1;
        repeat (5) step();
        out_ack = 1'b0;
        exp = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5};
        check_log("fill_order", exp);

        // Streaming at occupancy 2
        dut_log.delete();
        for (int i = 0; i < 2; i++) begin
            in_req = 1'b1; in_data = DW'(100 + i);
            step();
        end
        out_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = DW'(102 + i);
            step();
            check("stream_occ", 32'(occupancy), 32'd2);
        end
        in_req = 1'b0;
        repeat (3) step();
        out_ack = 1'b0;
        exp.delete();
        for (int i = 0; i < 12; i++) exp.push_back(DW'(100 + i));
        check_log("stream_order", exp);

        // Reset with occupancy 3 and both requests high
        for (int i = 0; i < 3; i++) begin
            in_req = 1'b1; in_data = DW'(7 + i);
            step();
        end
        check("prerst_occ", 32'(occupancy), 32'd3);
        rst = 1'b1; out_ack = 1'b1;
        step();
        rst = 1'b0; in_req = 1'b0; out_ack = 1'b0;
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_req", 32'(out_if.req), 32'd0);
        check("midrst_ack", 32'(in_if.ack), 32'd1);
        dut_log.delete();
        in_req = 1'b1; in_data = 18'h155;
        step();
        in_req = 1'b0; out_ack = 1'b1;
        repeat (2) step();
        out_ack = 1'b0;
        exp = '{18'h155};
        check_log("postrst_first", exp);

        // Random traffic: producer-heavy, then consumer-heavy, with rare resets
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 600; i++) begin
                in_req  = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                out_ack = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                in_data = DW'($urandom);
                rst     = ($urandom_range(0, 99) == 0);
                step();
            end
        end
        rst = 1'b0; in_req = 1'b0; out_ack = 1'b0;
        step();
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/input_buffer.md
# input_buffer

Per-input-port flit FIFO for the router. It accepts flits from an incoming link over a req/ack handshake, stores them in order, and presents the head flit to the switch stage. The switch stage's output multiplexer selects one buffer per output port and returns the ack. One instance sits on each of the five router input ports (local, west, north, east, south), directly upstream of the switch.

## Interface
- `DATA_WIDTH`, 18: flit width in bits.
- `DEPTH`, 4: FIFO capacity in flits. Power of two, ≥ 2.
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_rack_io`  ReqAckIO (link side): `req` input 1, `data` input DATA_WIDTH, `ack` output 1.
- `out_rack_io`  ReqAckIO (switch side): `req` output 1, `data` output DATA_WIDTH, `ack` input 1.
- `occupancy`  output  $clog2(DEPTH)+1: number of flits currently stored.
- `full`  output 1: occupancy == DEPTH.
- `empty`  output 1: occupancy == 0.

## Operation
- Storage: DEPTH × DATA_WIDTH register array, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits, plus a count register. Pointers wrap modulo DEPTH by natural overflow.
- Push (link side):
  - `in_rack_io.ack = !full`, combinational from registered state only. It never depends on `in_rack_io.req` or `out_rack_io.ack`.
  - A push occurs in a cycle where `in_rack_io.req && in_rack_io.ack`.
  - On push, `mem[wr_ptr] <= in_rack_io.data` and `wr_ptr` increments.
- Pop (switch side):
  - `out_rack_io.req = !empty`.
  - `out_rack_io.data = mem[rd_ptr]`. When empty, data is driven to `'0`.
  - A pop occurs in a cycle where `out_rack_io.req && out_rack_io.ack`, and `rd_ptr` increments.
  - `out_rack_io.ack` is ignored while empty.
- Count update: push only gives +1; pop only gives −1; push and pop in the same cycle leave the count unchanged and move both pointers.
- Full plus pop:
  - `in_rack_io.ack` is 0 in that cycle, so no push occurs.
  - The freed slot is offered as `ack=1` from the next cycle.
- Empty plus incoming req: no pop is possible. The flit becomes visible on `out_rack_io` the following cycle. There is no combinational bypass.
- Order: strict FIFO, no flit dropped or duplicated. Data is not inspected or modified.
- `full`, `empty` and `occupancy` derive from the count register.

## Timing
- Reset (`rst`=1 at a clock edge):
  - `wr_ptr`, `rd_ptr` and count go to 0.
  - Outputs next cycle: `out_rack_io.req`=0, `out_rack_io.data`='0, `in_rack_io.ack`=1, `occupancy`=0, `empty`=1, `full`=0.
  - Memory contents are not reset.
- Reset mid-operation: all stored flits are discarded. A push or pop coinciding with `rst`=1 is ignored, since reset has priority.
- Latency: a flit pushed at edge N appears on `out_rack_io` with `req`=1 after edge N. This is 1 cycle minimum from link accept to switch offer.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < occupancy < DEPTH.
- `out_rack_io.req` and `data` are stable while `ack`=0 and no reset occurs.
- There is no combinational path from `in_rack_io` to `out_rack_io`, or from `out_rack_io.ack` to `in_rack_io.ack`.

## Test plan
- Reset, then idle:
  - `in_rack_io.ack`=1, `out_rack_io.req`=0, `occupancy`=0, `empty`=1.
  - Then hold `out_rack_io.ack`=1 with no push: nothing changes.
- Single flit 18'h2ABCD pushed at cycle 1, `out_rack_io.ack`=0:
  - Cycle 2: `out_rack_io.req`=1, data=18'h2ABCD, `occupancy`=1, held while ack=0.
  - Ack at cycle 4 → `empty`=1 at cycle 5.
- Fill DEPTH=4 with 1, 2, 3, 4, ack=0:
  - After the 4th push, `full`=1 and `in_rack_io.ack`=0.
  - A 5th flit (5) is held off.
  - Pop one → `ack` returns 1 the next cycle, 5 is accepted, and output order is 1, 2, 3, 4, 5.
- Simultaneous push and pop at occupancy 2, streamed for 10 cycles with incrementing data:
  - `occupancy` stays at 2.
  - Pointers wrap at least twice.
  - Output sequence is exactly the input sequence delayed by 2 flits.
- Full plus pop in the same cycle with `in_rack_io.req`=1: no push that cycle, `occupancy`=3 afterwards, push accepted the next cycle.
- Assert `rst` with occupancy 3 and both req high:
  - Next cycle `occupancy`=0, `out_rack_io.req`=0, `in_rack_io.ack`=1.
  - A flit pushed after reset is the first one output.
